mux_display_ctrl: RTL and testbench

- Parametrised multiplexed 7-segment controller; successor to the fixed 4-digit/8-bit display driver in the training-scheduler display path.
- Converts a DATA_W-bit binary value to BCD sequentially (shift-add-3), so there are no combinational divide/modulo chains.
- Scans NUM_DIGITS digits from an internal prescaler; supports leading-zero blanking, a decimal point and an overflow indication.

---
 rtl/disp_pkg.sv | 56 +++++
 rtl/bin2bcd_seq.sv | 99 +++++++++
 rtl/mux_display_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mux_display_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display path.
// - Active-low segment patterns, ordered {g,f,e,d,c,b,a}.
// - seg_decode: BCD nibble to segment pattern. Codes 10-15 decode to blank.
// - pow10: a constant power of ten, used for the overflow threshold.
// - bcd_state_e: states of the sequential binary-to-BCD converter.
package disp_pkg;

    typedef longint unsigned u64_t;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } bcd_state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic u64_t pow10(input int unsigned n);
        u64_t r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - begin a conversion of bin; accepted in IDLE or DONE
//   bin       - DATA_W-bit binary input, captured when start is accepted
//   busy      - high in SHIFT and DONE
//   done      - high for the single DONE cycle; bcd is final while it is high
//   bcd       - NUM_DIGITS packed BCD digits, digit 0 in bits [3:0]
// Only the low NUM_DIGITS digits are kept: bits only ever move upward in
// shift-add-3, so truncating the accumulator leaves the kept digits exact.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    bcd_state_e        state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BCD_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BCD_W-1:0]  adj;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        // Add 3 to every nibble >= 5 before the shift.
        adj = acc_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StShift;
                    sr_d    = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                acc_d = {adj[BCD_W-2:0], sr_q[DATA_W-1]};
                sr_d  = sr_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = acc_q;

endmodule

// File: rtl/mux_display_ctrl.sv
// Multiplexed 7-segment display controller.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   value     - binary number to display, captured on load
//   load      - 1-cycle strobe; the value is queued (last load wins) and
//               converted as soon as the converter can accept it
//   dp_en     - per-digit decimal point enable, sampled live
//   busy      - a load is queued or a conversion is running
//   overflow  - displayed value does not fit in NUM_DIGITS digits
//   anode     - active-low one-hot digit select, bit 0 = ones
//   seg       - active-low segments {g,f,e,d,c,b,a}
//   dp        - active-low decimal point
// The display register only changes when a conversion finishes, so a partial
// conversion is never shown.
module mux_display_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DATA_W      = 14,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] dp_en,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W     = $clog2(REFRESH_DIV);
    localparam u64_t        OVF_LIMIT = pow10(NUM_DIGITS);

    logic                    pend_q, pend_d;
    logic [DATA_W-1:0]       pend_val_q, pend_val_d;
    logic                    cur_ovf_q, cur_ovf_d;
    logic                    ovf_q, ovf_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    core_busy;
    logic                    core_done;
    logic [4*NUM_DIGITS-1:0] core_bcd;
    logic                    core_accept;

    logic [NUM_DIGITS-1:0]   zero_from;
    logic [NUM_DIGITS-1:0]   one_hot;
    logic [3:0]              cur_nib;
    logic                    cur_zero;
    logic                    cur_dp_en;
    logic                    run_zero;
    logic                    blank;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (pend_q),
        .bin   (pend_val_q),
        .busy  (core_busy),
        .done  (core_done),
        .bcd   (core_bcd)
    );

    // The converter accepts a start when idle or in its final (DONE) cycle.
    assign core_accept = pend_q && (!core_busy || core_done);

    // Load queue, overflow tracking and display register.
    always_comb begin
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        cur_ovf_d  = cur_ovf_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;

        if (core_accept) begin
            pend_d    = 1'b0;
            cur_ovf_d = (u64_t'(pend_val_q) >= OVF_LIMIT);
        end
        // A load on the accept cycle re-queues, so the newest value is not lost.
        if (load) begin
            pend_d     = 1'b1;
            pend_val_d = value;
        end
        // cur_ovf_q still belongs to the finishing conversion here.
        if (core_done) begin
            disp_d = core_bcd;
            ovf_d  = cur_ovf_q;
        end
    end

    // Prescaler, scan index and registered digit outputs.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // zero_from[i]: digits i..NUM_DIGITS-1 are all zero.
        zero_from = '0;
        run_zero  = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            run_zero     = run_zero && (disp_q[4*i +: 4] == 4'd0);
            zero_from[i] = run_zero;
        end

        one_hot   = '0;
        cur_nib   = '0;
        cur_zero  = 1'b0;
        cur_dp_en = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                one_hot[i] = 1'b1;
                cur_nib    = disp_q[4*i +: 4];
                cur_zero   = zero_from[i];
                cur_dp_en  = dp_en[i];
            end
        end

        blank = (BLANK_LZ != 0) && (idx_q != '0) && cur_zero;

        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(cur_nib);
        end
        anode_d = ~one_hot;
        dp_d    = ~cur_dp_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            cur_ovf_q  <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
            anode_q    <= '1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            cur_ovf_q  <= cur_ovf_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign busy     = pend_q | core_busy;
    assign overflow = ovf_q;
    assign anode    = anode_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_mux_display_ctrl.sv
// Directed bench for mux_display_ctrl: one instance with leading-zero
// blanking, one without, sharing all inputs.
module tb_mux_display_ctrl;

    localparam int unsigned ND = 4;
    localparam int unsigned DW = 14;
    localparam int unsigned RD = 4;

    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12;
    localparam logic [6:0] S6 = 7'h02;
    localparam logic [6:0] S7 = 7'h78;
    localparam logic [6:0] S9 = 7'h10;
    localparam logic [6:0] SB = 7'h7F;
    localparam logic [6:0] SD = 7'h3F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] value = '0;
    logic [ND-1:0] dp_en = '0;

    logic          busy_a, ovf_a, dp_a;
    logic [ND-1:0] anode_a;
    logic [6:0]    seg_a;
    logic          busy_b, ovf_b, dp_b;
    logic [ND-1:0] anode_b;
    logic [6:0]    seg_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_display_ctrl #(
        .NUM_DIGITS  (ND),
        .DATA_W      (DW),
        .REFRESH_DIV (RD),
        .BLANK_LZ    (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .dp_en    (dp_en),
        .busy     (busy_a),
        .overflow (ovf_a),
        .anode    (anode_a),
        .seg      (seg_a),
        .dp       (dp_a)
    );

    mux_display_ctrl #(
        .NUM_DIGITS  (ND),
        .DATA_W      (DW),
        .REFRESH_DIV (RD),
        .BLANK_LZ    (0)
    ) dut_nb (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .dp_en    (dp_en),
        .busy     (busy_b),
        .overflow (ovf_b),
        .anode    (anode_b),
        .seg      (seg_b),
        .dp       (dp_b)
    );

    // Load strobe sampled by exactly one rising edge; returns at the
    // falling edge after that rising edge.
    task automatic do_load(input logic [DW-1:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 200; c++) begin
            if (!busy_a) break;
            @(negedge clk);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy_a);
        end
    endtask

    // Records one full scan of both instances, indexed by digit.
    task automatic capture(input string name, output logic [ND-1:0][6:0] sa,
                           output logic [ND-1:0][6:0] sb, output logic [ND-1:0] da);
        logic [ND-1:0] seen;
        int            bad;
        int            d;
        seen = '0;
        bad  = 0;
        sa   = '0;
        sb   = '0;
        da   = '0;
        @(negedge clk);
        for (int c = 0; c < 4 * int'(RD * ND) && seen != '1; c++) begin
            @(negedge clk);
            case (anode_a)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            if (anode_b !== anode_a) bad++;
            if (d < 0) begin
                bad++;
            end else begin
                sa[d]   = seg_a;
                sb[d]   = seg_b;
                da[d]   = dp_a;
                seen[d] = 1'b1;
            end
        end
        checks++;
        if (seen !== 4'b1111 || bad != 0) begin
            failures++;
            $display("FAIL %s_scan: digits seen=%b bad anode samples=%0d required 1111/0",
                     name, seen, bad);
        end
    endtask

    task automatic test_reset();
        logic [ND-1:0][6:0] sa, sb;
        logic [ND-1:0]      da;
        logic [3:0]         one;
        logic [3:0]         exp_an;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (anode_a !== 4'b1111 || seg_a !== SB || dp_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs: anode=%b seg=%h dp=%b required 1111/7f/1",
                     anode_a, seg_a, dp_a);
        end
        checks++;
        if (busy_a !== 1'b0 || ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: busy=%b overflow=%b required 0/0", busy_a, ovf_a);
        end
        rst = 1'b0;
        one = 4'b0001;
        // Each digit slot lasts RD clocks, starting from digit 0.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_an = ~(one << (k / 4));
            checks++;
            if (anode_a !== exp_an) begin
                failures++;
                $display("FAIL reset_anode_seq[%0d]: got %b required %b", k, anode_a, exp_an);
            end
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy: got %b required 0", busy_a);
        end
        capture("reset", sa, sb, da);
        checks++;
        if (sa !== {SB, SB, SB, S0}) begin
            failures++;
            $display("FAIL reset_digits_blank: got %h required %h", sa, {SB, SB, SB, S0});
        end
        checks++;
        if (sb !== {S0, S0, S0, S0}) begin
            failures++;
            $display("FAIL reset_digits_noblank: got %h required %h", sb, {S0, S0, S0, S0});
        end
    endtask

    task automatic test_load_1234();
        logic [ND-1:0][6:0] sa, sb;
        logic [ND-1:0]      da;
        int                 n;
        dp_en = 4'b0000;
        do_load(14'd1234);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (!busy_a) break;
            n++;
            // Last busy sample: display register must still hold the old value.
            if (n == 16) begin
                checks++;
                if (dut.disp_q !== 16'h0000) begin
                    failures++;
                    $display("FAIL load_no_early_update: got %h required 0000", dut.disp_q);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL load_busy_cycles: got %0d required 16", n);
        end
        checks++;
        if (dut.disp_q !== 16'h1234) begin
            failures++;
            $display("FAIL load_display_update: got %h required 1234", dut.disp_q);
        end
        checks++;
        if (ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL load_overflow: got %b required 0", ovf_a);
        end
        capture("load1234", sa, sb, da);
        checks++;
        if (sa !== {S1, S2, S3, S4} || sb !== {S1, S2, S3, S4}) begin
            failures++;
            $display("FAIL load1234_digits: got %h/%h required %h", sa, sb, {S1, S2, S3, S4});
        end
        checks++;
        if (da !== 4'b1111) begin
            failures++;
            $display("FAIL load1234_dp: got %b required 1111", da);
        end
    endtask

    task automatic test_blanking();
        logic [ND-1:0][6:0] sa, sb;
        logic [ND-1:0]      da;
        do_load(14'd7);
        wait_idle("blank7");
        capture("blank7", sa, sb, da);
        checks++;
        if (sa !== {SB, SB, SB, S7}) begin
            failures++;
            $display("FAIL blank7_lz1: got %h required %h", sa, {SB, SB, SB, S7});
        end
        checks++;
        if (sb !== {S0, S0, S0, S7}) begin
            failures++;
            $display("FAIL blank7_lz0: got %h required %h", sb, {S0, S0, S0, S7});
        end
        // Interior zeros below a non-zero digit stay lit.
        do_load(14'd1005);
        wait_idle("blank1005");
        capture("blank1005", sa, sb, da);
        checks++;
        if (sa !== {S1, S0, S0, S5}) begin
            failures++;
            $display("FAIL blank1005_lz1: got %h required %h", sa, {S1, S0, S0, S5});
        end
        do_load(14'd40);
        wait_idle("blank40");
        capture("blank40", sa, sb, da);
        checks++;
        if (sa !== {SB, SB, S4, S0}) begin
            failures++;
            $display("FAIL blank40_lz1: got %h required %h", sa, {SB, SB, S4, S0});
        end
    endtask

    task automatic test_overflow();
        logic [ND-1:0][6:0] sa, sb;
        logic [ND-1:0]      da;
        dp_en = 4'b0001;
        do_load(14'd12000);
        wait_idle("ovf12000");
        checks++;
        if (ovf_a !== 1'b1 || ovf_b !== 1'b1) begin
            failures++;
            $display("FAIL ovf12000_flag: got %b/%b required 1", ovf_a, ovf_b);
        end
        capture("ovf12000", sa, sb, da);
        checks++;
        if (sa !== {SD, SD, SD, SD} || sb !== {SD, SD, SD, SD}) begin
            failures++;
            $display("FAIL ovf12000_dash: got %h/%h required %h", sa, sb, {SD, SD, SD, SD});
        end
        checks++;
        if (da !== 4'b1110) begin
            failures++;
            $display("FAIL ovf12000_dp: got %b required 1110", da);
        end
        dp_en = 4'b0000;
        do_load(14'd10000);
        wait_idle("ovf10000");
        checks++;
        if (ovf_a !== 1'b1) begin
            failures++;
            $display("FAIL ovf10000_flag: got %b required 1", ovf_a);
        end
        do_load(14'd9999);
        wait_idle("ovf9999");
        checks++;
        if (ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL ovf9999_flag: got %b required 0", ovf_a);
        end
        capture("ovf9999", sa, sb, da);
        checks++;
        if (sa !== {S9, S9, S9, S9}) begin
            failures++;
            $display("FAIL ovf9999_digits: got %h required %h", sa, {S9, S9, S9, S9});
        end
    endtask

    task automatic test_back_to_back();
        logic [ND-1:0][6:0] sa, sb;
        logic [ND-1:0]      da;
        logic [15:0]        prev;
        logic [15:0]        seen_q[$];
        int                 n;
        do_load(14'd1234);
        @(negedge clk);
        @(negedge clk);
        do_load(14'd42);
        do_load(14'd56);
        // Busy samples taken so far: the edges of the first load (1), the two
        // waits (2) and the two queued loads (4).
        n    = 7;
        prev = 16'h9999;
        for (int c = 0; c < 100; c++) begin
            if (!busy_a) break;
            @(negedge clk);
            if (busy_a) n++;
            if (dut.disp_q !== prev) begin
                seen_q.push_back(dut.disp_q);
                prev = dut.disp_q;
            end
        end
        checks++;
        if (n != 31) begin
            failures++;
            $display("FAIL b2b_busy_cycles: got %0d required 31", n);
        end
        checks++;
        if (seen_q.size() != 2 || seen_q[0] !== 16'h1234 || seen_q[1] !== 16'h0056) begin
            failures++;
            $display("FAIL b2b_display_seq: got %0d updates first=%h last=%h required 1234 then 0056",
                     seen_q.size(), (seen_q.size() > 0) ? seen_q[0] : 16'hxxxx,
                     (seen_q.size() > 0) ? seen_q[seen_q.size()-1] : 16'hxxxx);
        end
        capture("b2b", sa, sb, da);
        checks++;
        if (sa !== {SB, SB, S5, S6}) begin
            failures++;
            $display("FAIL b2b_digits: got %h required %h", sa, {SB, SB, S5, S6});
        end
    endtask

    task automatic test_reset_mid();
        logic [ND-1:0][6:0] sa, sb;
        logic [ND-1:0]      da;
        do_load(14'd12000);
        wait_idle("rstmid_pre");
        do_load(14'd1234);
        repeat (4) @(negedge clk);
        dp_en = 4'b0100;
        rst   = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_status: busy=%b overflow=%b required 0/0", busy_a, ovf_a);
        end
        checks++;
        if (anode_a !== 4'b1111 || seg_a !== SB || dp_a !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_outputs: anode=%b seg=%h dp=%b required 1111/7f/1",
                     anode_a, seg_a, dp_a);
        end
        checks++;
        if (dut.disp_q !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_display: got %h required 0000", dut.disp_q);
        end
        rst = 1'b0;
        capture("rstmid", sa, sb, da);
        checks++;
        if (sa !== {SB, SB, SB, S0}) begin
            failures++;
            $display("FAIL rstmid_digits: got %h required %h", sa, {SB, SB, SB, S0});
        end
        checks++;
        if (da !== 4'b1011) begin
            failures++;
            $display("FAIL rstmid_dp: got %b required 1011", da);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_restart: busy=%b required 0", busy_a);
        end
    endtask

    initial begin
        test_reset();
        test_load_1234();
        test_blanking();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
